snake_dir_ctrl: RTL and testbench

//  Direction stage directly downstream of the PS/2 key decoder. Takes its four key

---
 rtl/snake_dir_ctrl.sv | 166 ++++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// Snake direction stage: synchronises PS/2 key levels, queues up to two turn
// requests and commits one per game tick. Macro SNAKE_REVERSE_FILTER_EN rejects reversals.
module snake_dir_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [1:0]  INIT_DIR    = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_left,
  input  logic       key_down,
  input  logic       key_right,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic       pending,
  output logic       q_full,
  output logic       req_drop
);

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  // Bit index equals the direction code (0=up 1=left 2=down 3=right).
  logic [3:0] key_vec;
  assign key_vec = {key_right, key_down, key_left, key_up};

  logic [3:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]                  prev_q, prev_d;
  logic [3:0]                  sync_out, key_rise;

  q_state_e   state_q, state_d;
  logic [1:0] slot0_q, slot0_d;
  logic [1:0] slot1_q, slot1_d;
  logic [1:0] dir_q, dir_d;
  logic       dir_changed_q, dir_changed_d;
  logic       req_drop_q, req_drop_d;

  logic       req_valid;
  logic [1:0] req_dir;
  logic [1:0] ref_dir;
  logic       is_reversal;
  logic       req_ok;
  logic       do_pop;
  logic       do_push;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], key_vec[i]};
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
    prev_d   = sync_out;
    key_rise = sync_out & ~prev_q;
  end

  // Lowest index wins: up > left > down > right.
  always_comb begin
    req_valid = |key_rise;
    req_dir   = 2'd3;
    if (key_rise[0]) begin
      req_dir = 2'd0;
    end else if (key_rise[1]) begin
      req_dir = 2'd1;
    end else if (key_rise[2]) begin
      req_dir = 2'd2;
    end
  end

  // Requests are compared against where the snake will be heading once the
  // queue drains, i.e. the tail, even if the head is being popped this cycle.
  always_comb begin
    ref_dir = dir_q;
    case (state_q)
      Q_ONE:   ref_dir = slot0_q;
      Q_FULL:  ref_dir = slot1_q;
      default: ref_dir = dir_q;
    endcase
  end

`ifdef SNAKE_REVERSE_FILTER_EN
  assign is_reversal = (req_dir == (ref_dir ^ 2'd2));
`else
  assign is_reversal = 1'b0;
`endif

  assign req_ok  = req_valid && (req_dir != ref_dir) && !is_reversal;
  assign do_pop  = tick && (state_q != Q_EMPTY);
  assign do_push = req_ok && ((state_q != Q_FULL) || do_pop);

  always_comb begin
    state_d       = state_q;
    slot0_d       = slot0_q;
    slot1_d       = slot1_q;
    dir_d         = dir_q;
    dir_changed_d = do_pop;
    req_drop_d    = req_valid && !do_push;

    if (do_pop) begin
      dir_d = slot0_q;
    end

    case (state_q)
      Q_EMPTY: begin
        if (do_push) begin
          state_d = Q_ONE;
          slot0_d = req_dir;
        end
      end
      Q_ONE: begin
        if (do_pop && do_push) begin
          slot0_d = req_dir;
        end else if (do_pop) begin
          state_d = Q_EMPTY;
        end else if (do_push) begin
          state_d = Q_FULL;
          slot1_d = req_dir;
        end
      end
      Q_FULL: begin
        if (do_pop) begin
          slot0_d = slot1_q;
          if (do_push) begin
            slot1_d = req_dir;
          end else begin
            state_d = Q_ONE;
          end
        end
      end
      default: begin
        state_d = Q_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      prev_q        <= '0;
      state_q       <= Q_EMPTY;
      slot0_q       <= '0;
      slot1_q       <= '0;
      dir_q         <= INIT_DIR;
      dir_changed_q <= 1'b0;
      req_drop_q    <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      slot0_q       <= slot0_d;
      slot1_q       <= slot1_d;
      dir_q         <= dir_d;
      dir_changed_q <= dir_changed_d;
      req_drop_q    <= req_drop_d;
    end
  end

  assign dir         = dir_q;
  assign dir_changed = dir_changed_q;
  assign pending     = (state_q != Q_EMPTY);
  assign q_full      = (state_q == Q_FULL);
  assign req_drop    = req_drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random key/tick traffic
// checked every cycle against a queue-based reference model.
module tb_snake_dir_ctrl;

  localparam int unsigned S        = 2;
  localparam logic [1:0]  INIT     = 2'd3;
`ifdef SNAKE_REVERSE_FILTER_EN
  localparam bit          FILTER   = 1'b1;
`else
  localparam bit          FILTER   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up = 1'b0, key_left = 1'b0, key_down = 1'b0, key_right = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] dir;
  logic       dir_changed, pending, q_full, req_drop;

  snake_dir_ctrl #(.SYNC_STAGES(S), .INIT_DIR(INIT)) dut (
    .clk(clk), .rst(rst),
    .key_up(key_up), .key_left(key_left), .key_down(key_down), .key_right(key_right),
    .tick(tick), .dir(dir), .dir_changed(dir_changed),
    .pending(pending), .q_full(q_full), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: key samples per edge, a plain FIFO and the committed direction.
  logic [3:0] hist[$];
  logic [1:0] mq[$];
  logic [1:0] m_dir = INIT;
  logic       m_dc = 1'b0;
  logic       m_drop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] rise;
    logic [1:0] req, r;
    bit         accept, pop;
    if (rst) begin
      hist.delete();
      for (int i = 0; i <= int'(S); i++) hist.push_back(4'b0);
      mq.delete();
      m_dir  = INIT;
      m_dc   = 1'b0;
      m_drop = 1'b0;
    end else begin
      // Level seen at edge e was sampled S edges earlier; edge compares with one before.
      rise   = hist[S-1] & ~hist[S];
      accept = 0;
      m_drop = 1'b0;
      pop    = tick && (mq.size() > 0);
      if (rise != 4'b0) begin
        req = 2'd3;
        for (int i = 3; i >= 0; i--) if (rise[i]) req = 2'(i);
        r = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
        if (req == r || (FILTER && req == (r ^ 2'd2))) m_drop = 1'b1;
        else if (mq.size() == 2 && !pop)              m_drop = 1'b1;
        else                                           accept = 1;
      end
      m_dc = pop;
      if (pop) m_dir = mq.pop_front();
      if (accept) mq.push_back(req);
      hist.push_front({key_right, key_down, key_left, key_up});
      void'(hist.pop_back());
    end
  endtask

  task automatic compare_all();
    chk("dir",         32'(dir),         32'(m_dir));
    chk("dir_changed", 32'(dir_changed), 32'(m_dc));
    chk("pending",     32'(pending),     32'(mq.size() != 0));
    chk("q_full",      32'(q_full),      32'(mq.size() == 2));
    chk("req_drop",    32'(req_drop),    32'(m_drop));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_keys(input logic [3:0] kv);
    {key_right, key_down, key_left, key_up} = kv;
  endtask

  // Press for one cycle; returns right after the edge at which the request is decided.
  task automatic pulse_key(input logic [3:0] kv);
    set_keys(kv);
    step();
    set_keys(4'b0);
    step();
    step();
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst = 1'b1;
    for (int unsigned i = 0; i < cycles; i++) step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] kv;
    for (int i = 0; i <= int'(S); i++) hist.push_back(4'b0);
    #1;

    // Reset state
    do_reset(3);
    chk("rst.dir", 32'(dir), 32'd3);
    chk("rst.pending", 32'(pending), 32'd0);
    chk("rst.q_full", 32'(q_full), 32'd0);
    chk("rst.dir_changed", 32'(dir_changed), 32'd0);
    chk("rst.req_drop", 32'(req_drop), 32'd0);

    // Sync latency and a single commit
    set_keys(4'b0001);
    step();
    step();
    chk("lat.pending_early", 32'(pending), 32'd0);
    step();
    chk("lat.pending", 32'(pending), 32'd1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("t2.dir", 32'(dir), 32'd0);
    chk("t2.dir_changed", 32'(dir_changed), 32'd1);
    chk("t2.pending", 32'(pending), 32'd0);
    step();
    chk("t2.dir_changed_off", 32'(dir_changed), 32'd0);
    set_keys(4'b0);
    step();

    // Reversal request from dir=right
    do_reset(1);
    pulse_key(4'b0010);
    chk("rev.req_drop", 32'(req_drop), 32'(FILTER));
    chk("rev.pending", 32'(pending), 32'(!FILTER));
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("rev.dir", 32'(dir), FILTER ? 32'd3 : 32'd1);

    // Overflow while full
    do_reset(1);
    pulse_key(4'b0001);
    pulse_key(4'b0010);
    chk("full.q_full", 32'(q_full), 32'd1);
    pulse_key(4'b0100);
    chk("full.req_drop", 32'(req_drop), 32'd1);
    chk("full.q_full_kept", 32'(q_full), 32'd1);
    tick = 1'b1;
    step();
    chk("full.dir0", 32'(dir), 32'd0);
    step();
    chk("full.dir1", 32'(dir), 32'd1);
    tick = 1'b0;
    step();

    // Push and pop in the same cycle on a full queue
    do_reset(1);
    pulse_key(4'b0001);
    pulse_key(4'b0010);
    set_keys(4'b0100);
    step();
    set_keys(4'b0);
    step();
    tick = 1'b1;
    step();
    chk("pp.dir", 32'(dir), 32'd0);
    chk("pp.q_full", 32'(q_full), 32'd1);
    chk("pp.req_drop", 32'(req_drop), 32'd0);
    step();
    chk("pp.dir_left", 32'(dir), 32'd1);
    step();
    chk("pp.dir_down", 32'(dir), 32'd2);
    chk("pp.pending", 32'(pending), 32'd0);
    tick = 1'b0;

    // Mid-operation reset, then simultaneous keys
    pulse_key(4'b0001);
    pulse_key(4'b0010);
    do_reset(1);
    chk("mid.dir", 32'(dir), 32'd3);
    chk("mid.pending", 32'(pending), 32'd0);
    pulse_key(4'b0111);
    chk("sim.pending", 32'(pending), 32'd1);
    chk("sim.q_full", 32'(q_full), 32'd0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("sim.dir", 32'(dir), 32'd0);
    chk("sim.pending_after", 32'(pending), 32'd0);

    // Random traffic, including keys held through reset
    kv = 4'b0;
    for (int n = 0; n < 4000; n++) begin
      rst  = ($urandom_range(0, 249) == 0);
      tick = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) kv[b] = ~kv[b];
      set_keys(kv);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
